std_sram_singleport_arb2: RTL
=============================

Name: std_sram_singleport_arb2

Overview:
- Two-requester round-robin arbiter and sequencer for one single-port SRAM macro with registered output. It time-shares the single address/data port between requesters A and B.
- It tracks in-flight reads through a fixed-latency pipeline and returns each read result to the requester that issued it.
- Optional post-reset zero-fill sweep initialises the whole array before any request is accepted.
- Sits between two client engines (e.g. fetch/refill and maintenance) and the SRAM port.

Parameters:
- ADDR_WIDTH, 4, SRAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, SRAM data width.
- RD_LATENCY, 2, cycles from read issue (sram_en=1, sram_we=0) to valid sram_rdata; legal range 1..4.
- INIT_ENABLE, 1, 1 = zero-fill the array after reset; 0 = skip straight to service.

Ports:
- clk  input  1  clock, all state on rising edge
- aregrstn  input  1  asynchronous active-low reset
- a_valid  input  1  requester A request valid
- a_ready  output  1  A request accepted this cycle
- a_we  input  1  A write (1) / read (0)
- a_addr  input  ADDR_WIDTH  A address
- a_wdata  input  DATA_WIDTH  A write data
- a_rvalid  output  1  A read data valid, one-cycle pulse
- a_rdata  output  DATA_WIDTH  A read data
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata: same widths and meaning for requester B
- sram_en  output  1  SRAM port enable
- sram_we  output  1  SRAM write enable
- sram_addr  output  ADDR_WIDTH  SRAM address
- sram_wdata  output  DATA_WIDTH  SRAM write data
- sram_rdata  input  DATA_WIDTH  SRAM read data, valid RD_LATENCY cycles after issue
- init_done  output  1  high once service state entered; stays high until next reset

Behaviour:
- FSM states: INIT, RUN.
- Reset (aregrstn=0, asynchronous):
  - State = INIT if INIT_ENABLE else RUN.
  - Init counter = 0; round-robin pointer = A-preferred.
  - Read-tracking pipeline cleared.
  - All outputs 0, including init_done.
  - Outputs become functional on the first clock edge after release.
- INIT:
  - Each cycle drives sram_en=1, sram_we=1, sram_addr=counter, sram_wdata=0; counter increments.
  - a_ready=b_ready=0.
  - On the cycle counter = 2**ADDR_WIDTH-1 is written, next state = RUN and init_done=1 from that edge.
  - Zero-fill takes exactly 2**ADDR_WIDTH cycles.
- RUN arbitration (combinational grant, registered pointer):
  - Only A valid -> grant A; only B valid -> grant B.
  - Both valid -> grant the side named by the pointer.
  - Pointer moves to the non-granted side after every accepted request (A accepted -> B preferred, and vice versa). Unchanged when nothing is accepted.
  - x_ready = grant_x; handshake completes when x_valid & x_ready.
  - Requester must hold valid/we/addr/wdata stable until ready; the arbiter never drops a held request.
  - Starvation bound: a held request is granted within 2 cycles.
- SRAM drive in the accept cycle:
  - sram_en=1; sram_we/addr/wdata = granted requester's fields.
  - No accept -> sram_en=0, sram_we=0; addr/wdata don't-care (drive 0).
  - Zero added latency: the issue cycle equals the accept cycle.
- Read return:
  - Each issued read pushes {valid=1, id} into a RD_LATENCY-deep shift register; writes push valid=0.
  - When the stage-RD_LATENCY entry is valid, pulse x_rvalid for the tagged id for one cycle; x_rdata = sram_rdata in that cycle (combinational pass-through).
  - Non-addressed rdata holds its last value.
  - Back-to-back reads from either side return in issue order, one per cycle, with no bubbles. No response backpressure.
- Simultaneous events:
  - Requests during INIT are stalled, not lost.
  - A write issued in the cycle after a read to the same address does not affect that read's returned data (SRAM order).
  - Reset mid-INIT restarts the sweep.
  - Reset with reads in flight discards them: no rvalid after reset.

Test Plan:
- INIT sweep, ADDR_WIDTH=4, a_valid held high from reset release:
  - Expect 16 consecutive writes of 0 to addr 0..15, a_ready=0 throughout.
  - init_done rises at cycle 16; A accepted at cycle 16.
- Write then read on A: write addr 5 data 0xA5, then read addr 5:
  - a_rvalid pulses exactly 2 cycles after the read accept with a_rdata=0xA5.
  - b_rvalid stays 0.
- Contention: a_valid and b_valid both held high for 6 cycles, pointer initially A:
  - Grants alternate A,B,A,B,A,B.
  - Read responses return to the matching id in the same order.
- Back-to-back reads: A reads addr 1,2,3 on consecutive cycles (pre-written 0x11,0x22,0x33):
  - a_rvalid high 3 consecutive cycles, data 0x11,0x22,0x33.
- Reset mid-flight: aregrstn asserted 1 cycle after a read accept:
  - All outputs 0 immediately; no rvalid after release.
  - INIT restarts at addr 0.
- INIT_ENABLE=0: init_done=1 and requests accepted on the first edge after reset release.
- RD_LATENCY=3 variant: response arrives 3 cycles after accept.

Source files
------------

// File: rtl/std_sram_singleport_arb2.sv
// std_sram_singleport_arb2: round-robin two-requester sequencer for a single-port SRAM
// with optional post-reset zero-fill and fixed-latency read-return routing.
module std_sram_singleport_arb2 #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int RD_LATENCY  = 2,
  parameter int INIT_ENABLE = 1
) (
  input  logic                  clk,
  input  logic                  aregrstn,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  init_done
);
  typedef enum logic {INIT, RUN} state_t;
  state_t                r_state, w_state_nx;
  logic                  r_live, r_ptr;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [RD_LATENCY-1:0] r_pv, r_pid;
  logic [DATA_WIDTH-1:0] r_a_rdata, r_b_rdata;
  logic                  w_init, w_run, w_gnt_a, w_gnt_b, w_rd;
  // r_live keeps every output at 0 until the first edge after reset release
  assign w_init    = r_live && r_state == INIT;
  assign w_run     = r_live && r_state == RUN;
  assign w_gnt_a   = w_run && a_valid && (!b_valid || !r_ptr);
  assign w_gnt_b   = w_run && b_valid && !w_gnt_a;
  assign w_rd      = (w_gnt_a && !a_we) || (w_gnt_b && !b_we);
  assign a_ready   = w_gnt_a;
  assign b_ready   = w_gnt_b;
  assign init_done = w_run;
  assign a_rvalid  = r_pv[RD_LATENCY-1] && !r_pid[RD_LATENCY-1];
  assign b_rvalid  = r_pv[RD_LATENCY-1] && r_pid[RD_LATENCY-1];
  assign a_rdata   = a_rvalid ? sram_rdata : r_a_rdata;
  assign b_rdata   = b_rvalid ? sram_rdata : r_b_rdata;
  always_comb begin
    w_state_nx = (w_init && r_cnt == '1) ? RUN : r_state;
    sram_en    = w_init || w_gnt_a || w_gnt_b;
    sram_we    = w_init || (w_gnt_a ? a_we : w_gnt_b && b_we);
    sram_addr  = w_init ? r_cnt : w_gnt_a ? a_addr : w_gnt_b ? b_addr : '0;
    sram_wdata = w_gnt_a ? a_wdata : w_gnt_b ? b_wdata : '0;
  end
  always_ff @(posedge clk or negedge aregrstn) begin
    if (!aregrstn) begin
      r_state   <= (INIT_ENABLE != 0) ? INIT : RUN;
      r_live    <= 1'b0;
      r_ptr     <= 1'b0;
      r_cnt     <= '0;
      r_pv      <= '0;
      r_pid     <= '0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_state_nx;
      if (w_init) r_cnt <= r_cnt + 1'b1;
      if (w_gnt_a || w_gnt_b) r_ptr <= w_gnt_a;
      r_pv[0]  <= w_rd;
      r_pid[0] <= w_gnt_b;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pv[i]  <= r_pv[i-1];
        r_pid[i] <= r_pid[i-1];
      end
      if (a_rvalid) r_a_rdata <= sram_rdata;
      if (b_rvalid) r_b_rdata <= sram_rdata;
    end
  end
endmodule
